// File: rtl/gbsha_fir_pkg.sv
// gbsha_fir_pkg: shared FIR state encoding and fixed-point helpers
// Provides the controller state type, the accumulator width rule and
// 64-bit round/saturate helpers that the output stage narrows afterwards.
package gbsha_fir_pkg;
    typedef enum logic [1:0] {LOAD, IDLE, MAC, OUT} state_t;
    function automatic int bw_acc(input int bw_in, input int n_taps);
        return 2 * bw_in + $clog2(n_taps);
    endfunction
    function automatic logic signed [63:0] round_shift(input logic signed [63:0] a, input int shift);
        return shift == 0 ? a : (a + (64'sd1 <<< (shift - 1))) >>> shift;
    endfunction
    function automatic logic signed [63:0] saturate(input logic signed [63:0] a, input int bw_out);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (bw_out - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        return a > hi ? hi : a < lo ? lo : a;
    endfunction
endpackage

// File: rtl/gbsha_fir_round_sat.sv
// gbsha_fir_round_sat: round half toward +inf, arithmetic shift, saturate to output width
// Ports: acc (BW_ACC signed accumulator in), y (BW_OUT signed result out).
module gbsha_fir_round_sat
    import gbsha_fir_pkg::*;
#(
    parameter int BW_ACC = 16,
    parameter int BW_OUT = 8,
    parameter int SHIFT  = 0
) (
    input  logic signed [BW_ACC-1:0] acc,
    output logic signed [BW_OUT-1:0] y
);
    assign y = BW_OUT'(saturate(round_shift(64'(acc), SHIFT), BW_OUT));
endmodule

// File: rtl/gbsha_top.sv
// gbsha_top: 8-in/8-out tile wrapper around gbsha_fir_mac
// Ports: io_in[0] clk, io_in[1] reset, io_in[7:2] x_in; io_out is y_out.
// Samples are always valid and reload is never requested from the tile pins.
module gbsha_top (
    input  logic [7:0] io_in,
    output logic [7:0] io_out
);
    logic unused_ready, unused_coef_loaded, unused_y_valid, unused_overrun;
    logic signed [7:0] y;
    assign io_out = y;
    gbsha_fir_mac u_fir (
        .clk         (io_in[0]),
        .reset       (io_in[1]),
        .x_in        (io_in[7:2]),
        .x_valid     (1'b1),
        .reload      (1'b0),
        .ready       (unused_ready),
        .coef_loaded (unused_coef_loaded),
        .y_out       (y),
        .y_valid     (unused_y_valid),
        .overrun     (unused_overrun)
    );
endmodule

// File: rtl/gbsha_fir_mac.sv
// gbsha_fir_mac: N-tap FIR with serial coefficient load and one time-shared MAC
// Ports: clk, reset (sync, active-high); x_in/x_valid coefficient or sample in;
// reload returns to coefficient loading; ready, coef_loaded status; y_out/y_valid
// registered result with one-cycle strobe; overrun sticky dropped-sample flag.
module gbsha_fir_mac
    import gbsha_fir_pkg::*;
#(
    parameter int N_TAPS = 4,
    parameter int BW_in  = 6,
    parameter int BW_out = 8,
    parameter int SHIFT  = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic signed [BW_in-1:0]  x_in,
    input  logic                     x_valid,
    input  logic                     reload,
    output logic                     ready,
    output logic                     coef_loaded,
    output logic signed [BW_out-1:0] y_out,
    output logic                     y_valid,
    output logic                     overrun
);
    localparam int BW_ACC = bw_acc(BW_in, N_TAPS);
    localparam int IW = $clog2(N_TAPS);
    localparam logic [IW-1:0] LAST = IW'(N_TAPS - 1);
    state_t state, state_n;
    logic [IW-1:0] idx, k;
    logic signed [BW_in-1:0] c [N_TAPS];
    logic signed [BW_in-1:0] x [N_TAPS];
    logic signed [BW_ACC-1:0] acc;
    logic signed [2*BW_in-1:0] prod;
    logic signed [BW_out-1:0] y_rs;
    assign prod = x[k] * c[k];
    gbsha_fir_round_sat #(.BW_ACC(BW_ACC), .BW_OUT(BW_out), .SHIFT(SHIFT)) u_round_sat (
        .acc (acc),
        .y   (y_rs)
    );
    // reload takes priority over a coincident sample in IDLE and over a write in LOAD
    always_comb begin
        state_n = state;
        ready = state == LOAD || state == IDLE;
        if (state == LOAD)
            state_n = x_valid && !reload && idx == LAST ? IDLE : LOAD;
        else if (state == IDLE)
            state_n = reload ? LOAD : x_valid ? MAC : IDLE;
        else if (state == MAC)
            state_n = k == LAST ? OUT : MAC;
        else
            state_n = IDLE;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= LOAD;
            idx <= '0;
            k <= '0;
            acc <= '0;
            y_out <= '0;
            y_valid <= 1'b0;
            overrun <= 1'b0;
            coef_loaded <= 1'b0;
            for (int i = 0; i < N_TAPS; i++) begin
                c[i] <= '0;
                x[i] <= '0;
            end
        end else begin
            state <= state_n;
            y_valid <= state == OUT;
            if (x_valid && !ready)
                overrun <= 1'b1;
            if (state == LOAD) begin
                if (reload)
                    idx <= '0;
                else if (x_valid) begin
                    c[idx] <= x_in;
                    idx <= idx == LAST ? '0 : idx + 1'b1;
                    if (idx == LAST)
                        coef_loaded <= 1'b1;
                end
            end else if (state == IDLE) begin
                if (reload) begin
                    for (int i = 0; i < N_TAPS; i++)
                        x[i] <= '0;
                    acc <= '0;
                    idx <= '0;
                    coef_loaded <= 1'b0;
                end else if (x_valid) begin
                    x[0] <= x_in;
                    for (int i = 1; i < N_TAPS; i++)
                        x[i] <= x[i-1];
                    acc <= '0;
                    k <= '0;
                end
            end else if (state == MAC) begin
                acc <= acc + {{(BW_ACC - 2*BW_in){prod[2*BW_in-1]}}, prod};
                k <= k + 1'b1;
            end else
                y_out <= y_rs;
        end
    end
endmodule

// File: tb/tb_gbsha_fir_mac.sv
// tb_gbsha_fir_mac: scoreboard bench for gbsha_fir_mac, SHIFT=0 and SHIFT=2 in lockstep
module tb_gbsha_fir_mac;
    localparam int N = 4;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic x_valid = 1'b0;
    logic reload = 1'b0;
    logic signed [5:0] x_in = '0;
    logic ready, coef_loaded, y_valid, overrun;
    logic ready2, coef_loaded2, y_valid2, overrun2;
    logic signed [7:0] y_out, y_out2;
    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int mc [N];
    int mx [N];
    int q0 [$];
    int q2 [$];
    int qt [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    gbsha_fir_mac #(.N_TAPS(N), .BW_in(6), .BW_out(8), .SHIFT(0)) dut (
        .clk(clk), .reset(reset), .x_in(x_in), .x_valid(x_valid), .reload(reload),
        .ready(ready), .coef_loaded(coef_loaded), .y_out(y_out), .y_valid(y_valid), .overrun(overrun)
    );
    gbsha_fir_mac #(.N_TAPS(N), .BW_in(6), .BW_out(8), .SHIFT(2)) dut2 (
        .clk(clk), .reset(reset), .x_in(x_in), .x_valid(x_valid), .reload(reload),
        .ready(ready2), .coef_loaded(coef_loaded2), .y_out(y_out2), .y_valid(y_valid2), .overrun(overrun2)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int mround(input int a, input int s);
        if (s == 0) return a;
        return (a + (1 << (s - 1))) >>> s;
    endfunction

    function automatic int msat(input int a);
        return a > 127 ? 127 : a < -128 ? -128 : a;
    endfunction

    always @(negedge clk) begin
        if (!reset && y_valid) begin
            if (q0.size() == 0)
                chk("stray_y_valid", 1, 0);
            else begin
                chk("y_out", y_out, q0.pop_front());
                chk("y_out_shift2", y_out2, q2.pop_front());
                chk("latency", cyc - qt.pop_front(), N + 1);
                chk("y_valid_pair", y_valid2, 1);
            end
        end
    end

    task automatic wait_ready();
        int t = 0;
        while (!ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!ready) chk("ready_timeout", 0, 1);
    endtask

    task automatic put_coef(input int i, input int v);
        wait_ready();
        x_valid = 1'b1;
        x_in = 6'(v);
        mc[i] = v;
        @(negedge clk);
        x_valid = 1'b0;
    endtask

    task automatic load4(input int a, input int b, input int c, input int d);
        put_coef(0, a);
        put_coef(1, b);
        put_coef(2, c);
        put_coef(3, d);
        chk("coef_loaded_after_load", coef_loaded, 1);
    endtask

    task automatic send(input int v);
        int acc = 0;
        wait_ready();
        x_valid = 1'b1;
        x_in = 6'(v);
        for (int i = N - 1; i > 0; i--) mx[i] = mx[i-1];
        mx[0] = v;
        for (int i = 0; i < N; i++) acc += mx[i] * mc[i];
        q0.push_back(msat(mround(acc, 0)));
        q2.push_back(msat(mround(acc, 2)));
        qt.push_back(cyc + 1);
        @(negedge clk);
        x_valid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while (q0.size() != 0 && t < 60) begin
            @(negedge clk);
            t++;
        end
        chk("drain_pending", q0.size(), 0);
    endtask

    task automatic reload_idle();
        wait_ready();
        reload = 1'b1;
        x_valid = 1'b1;
        x_in = 6'sd7;
        for (int i = 0; i < N; i++) mx[i] = 0;
        @(negedge clk);
        reload = 1'b0;
        x_valid = 1'b0;
        chk("coef_loaded_after_reload", coef_loaded, 0);
    endtask

    task automatic clear_model();
        for (int i = 0; i < N; i++) begin
            mc[i] = 0;
            mx[i] = 0;
        end
        q0.delete();
        q2.delete();
        qt.delete();
    endtask

    task automatic check_reset_state();
        chk("rst_y_out", y_out, 0);
        chk("rst_y_valid", y_valid, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_coef_loaded", coef_loaded, 0);
        chk("rst_coef_loaded2", coef_loaded2, 0);
        chk("rst_ready", ready, 1);
        chk("rst_ready2", ready2, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        clear_model();
        @(negedge clk);
        check_reset_state();
        reset = 1'b0;
        put_coef(0, 1);
        put_coef(1, 2);
        put_coef(2, 3);
        chk("coef_loaded_partial", coef_loaded, 0);
        put_coef(3, 4);
        chk("coef_loaded_full", coef_loaded, 1);
        send(1);
        for (int i = 0; i < 4; i++) send(0);
        drain();
        reload_idle();
        load4(-32, -32, -32, -32);
        for (int i = 0; i < 4; i++) send(-32);
        drain();
        reload_idle();
        load4(31, 31, 31, 31);
        for (int i = 0; i < 4; i++) send(-32);
        drain();
        reload_idle();
        load4(6, 0, 0, 0);
        send(1);
        send(-1);
        drain();
        reload_idle();
        load4(1, 2, 0, 0);
        chk("overrun_before", overrun, 0);
        send(3);
        @(negedge clk);
        chk("ready_in_mac", ready, 0);
        x_valid = 1'b1;
        x_in = 6'sd5;
        @(negedge clk);
        x_valid = 1'b0;
        chk("overrun_set", overrun, 1);
        drain();
        send(0);
        drain();
        chk("overrun_sticky", overrun, 1);
        chk("overrun_sticky2", overrun2, 1);
        send(2);
        @(negedge clk);
        reset = 1'b1;
        clear_model();
        @(negedge clk);
        check_reset_state();
        reset = 1'b0;
        repeat (N + 4) @(negedge clk);
        chk("no_stale_y_valid", y_valid, 0);
        load4(1, 2, 3, 4);
        send(5);
        drain();
        reload_idle();
        load4(0, 0, 0, 1);
        send(1);
        for (int i = 0; i < 3; i++) send(0);
        drain();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
